ram4: RTL and testbench



---
 rtl/ram4.sv | 63 ++++++
 tb/tb_ram4.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram4.sv
// ram4: four-word register memory with DMux4Way-style load steering and 4:1 read mux; define RAM4_READ_REG_EN for a registered read port
module ram4 #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic [1:0]       address,
    output logic [WIDTH-1:0] out,
    output logic [DEPTH-1:0] written
);
    logic [DEPTH-1:0] ld;
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] written_d, written_q;

    // steer the single load strobe to one word enable and compute next word/flag state
    always_comb begin
        ld = '0;
        ld[address] = load;
        mem_d = mem_q;
        for (int i = 0; i < DEPTH; i++)
            mem_d[i] = ld[i] ? in : mem_q[i];
        written_d = written_q | ld;
    end

    // word storage and sticky written flags, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            written_q <= '0;
        end else begin
            mem_q <= mem_d;
            written_q <= written_d;
        end
    end

    assign written = written_q;

`ifdef RAM4_READ_REG_EN
    logic [WIDTH-1:0] out_d, out_q;

    // read-before-write: capture the addressed word as it stood before the edge
    always_comb begin
        out_d = mem_q[address];
    end

    // registered read port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out_q <= '0;
        else
            out_q <= out_d;
    end

    assign out = out_q;
`else
    assign out = mem_q[address];
`endif
endmodule

// File: tb/tb_ram4.sv
// tb_ram4: scoreboard bench for ram4, both with and without RAM4_READ_REG_EN
module tb_ram4;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] din = '0;
    logic [1:0]  address = '0;
    logic [15:0] out;
    logic [3:0]  written;

    logic [15:0] model [4];
    logic [3:0]  model_wr;
    logic [15:0] exp_q [$];
    int vectors = 0;
    int miscompares = 0;

    ram4 #(.WIDTH(16), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in(din), .load(load),
        .address(address), .out(out), .written(written)
    );

    always #5 clk = ~clk;

    task automatic settle();
`ifdef RAM4_READ_REG_EN
        @(posedge clk);
        @(negedge clk);
`else
        #1;
`endif
    endtask

    task automatic write_word(input logic [1:0] a, input logic [15:0] d);
        @(negedge clk);
        address = a;
        din = d;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        model[a] = d;
        model_wr[a] = 1'b1;
    endtask

    task automatic test_reset();
        logic [15:0] e;
        rst_n = 1'b0;
        load = 1'b1;
        din = 16'hFFFF;
        address = 2'b10;
        for (int a = 0; a < 4; a++) model[a] = '0;
        model_wr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        rst_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            address = a[1:0];
            exp_q.push_back(model[a]);
            settle();
            e = exp_q.pop_front();
            vectors++;
            if (out !== e) begin
                miscompares++;
                $display("FAIL reset_read addr=%0d got=%h want=%h", a, out, e);
            end
        end
        vectors++;
        if (written !== model_wr) begin
            miscompares++;
            $display("FAIL reset_written got=%b want=%b", written, model_wr);
        end
    endtask

    task automatic test_per_word();
        logic [15:0] e;
        write_word(2'd0, 16'h1111);
        write_word(2'd1, 16'h2222);
        write_word(2'd2, 16'h3333);
        write_word(2'd3, 16'h4444);
        for (int a = 0; a < 4; a++) begin
            address = a[1:0];
            exp_q.push_back(model[a]);
            settle();
            e = exp_q.pop_front();
            vectors++;
            if (out !== e) begin
                miscompares++;
                $display("FAIL per_word_read addr=%0d got=%h want=%h", a, out, e);
            end
        end
        vectors++;
        if (written !== 4'b1111) begin
            miscompares++;
            $display("FAIL per_word_written got=%b want=1111", written);
        end
    endtask

    task automatic test_isolation();
        logic [15:0] e;
        write_word(2'd2, 16'hABCD);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            load = 1'b0;
            din = 16'h0000;
            address = c[1:0];
        end
        for (int a = 0; a < 4; a++) begin
            address = a[1:0];
            exp_q.push_back(model[a]);
            settle();
            e = exp_q.pop_front();
            vectors++;
            if (out !== e) begin
                miscompares++;
                $display("FAIL isolation_read addr=%0d got=%h want=%h", a, out, e);
            end
        end
    endtask

`ifndef RAM4_READ_REG_EN
    task automatic test_read_during_write();
        logic [15:0] e;
        write_word(2'd1, 16'h0005);
        @(negedge clk);
        address = 2'd1;
        load = 1'b1;
        din = 16'h0009;
        exp_q.push_back(model[1]);
        #1;
        e = exp_q.pop_front();
        vectors++;
        if (out !== e) begin
            miscompares++;
            $display("FAIL rdw_before got=%h want=%h", out, e);
        end
        model[1] = 16'h0009;
        exp_q.push_back(model[1]);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        vectors++;
        if (out !== e) begin
            miscompares++;
            $display("FAIL rdw_after got=%h want=%h", out, e);
        end
        @(negedge clk);
        load = 1'b0;
    endtask
`endif

    task automatic test_async_reset();
        logic [15:0] e;
        write_word(2'd0, 16'h0A0A);
        write_word(2'd1, 16'h1B1B);
        write_word(2'd2, 16'h2C2C);
        write_word(2'd3, 16'h3D3D);
        address = 2'd3;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        for (int a = 0; a < 4; a++) model[a] = '0;
        model_wr = '0;
        exp_q.push_back(model[3]);
        #1;
        e = exp_q.pop_front();
        vectors++;
        if (out !== e) begin
            miscompares++;
            $display("FAIL async_reset_out got=%h want=%h", out, e);
        end
        vectors++;
        if (written !== model_wr) begin
            miscompares++;
            $display("FAIL async_reset_written got=%b want=%b", written, model_wr);
        end
        for (int a = 0; a < 4; a++) begin
            address = a[1:0];
            exp_q.push_back(model[a]);
            #1;
            e = exp_q.pop_front();
            vectors++;
            if (out !== e) begin
                miscompares++;
                $display("FAIL async_reset_word addr=%0d got=%h want=%h", a, out, e);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

`ifdef RAM4_READ_REG_EN
    task automatic test_read_reg();
        logic [15:0] e;
        @(negedge clk);
        address = 2'd3;
        din = 16'h00AA;
        load = 1'b1;
        exp_q.push_back(model[3]);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        vectors++;
        if (out !== e) begin
            miscompares++;
            $display("FAIL read_reg_write_edge got=%h want=%h", out, e);
        end
        model[3] = 16'h00AA;
        model_wr[3] = 1'b1;
        @(negedge clk);
        load = 1'b0;
        exp_q.push_back(model[3]);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        vectors++;
        if (out !== e) begin
            miscompares++;
            $display("FAIL read_reg_next_edge got=%h want=%h", out, e);
        end
        vectors++;
        if (written !== model_wr) begin
            miscompares++;
            $display("FAIL read_reg_written got=%b want=%b", written, model_wr);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_per_word();
        test_isolation();
`ifndef RAM4_READ_REG_EN
        test_read_during_write();
`endif
        test_async_reset();
`ifdef RAM4_READ_REG_EN
        test_read_reg();
`endif
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
